// File: rtl/gpio_hex_io.sv
// gpio_hex_io: CPU GPIO word shown as hex on a multiplexed 7-segment display, debounced switches returned as GPIO input.
// Optional leading-zero blanking with `GPIO_HEX_BLANK_EN.
module gpio_hex_io #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DEB_TICK = 250000,
  parameter int SW_WIDTH = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         gpio_out,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [31:0]         gpio_in,
  output logic [6:0]          hex_seg,
  output logic [DIGITS-1:0]   hex_an
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_TICK);
  logic [31:0]         disp_q;
  logic [IW-1:0]       scan_idx;
  logic [CW-1:0]       scan_cnt;
  logic [DW-1:0]       deb_cnt;
  logic [SW_WIDTH-1:0] s1, s2, h0, h1, deb, all1, all0;
  logic [3:0]          nib;
  logic                blank, scan_wrap, deb_wrap;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign scan_wrap = scan_cnt == CW'(SCAN_DIV - 1);
  assign deb_wrap  = deb_cnt == DW'(DEB_TICK - 1);
  assign nib       = disp_q[{scan_idx, 2'b00} +: 4];
`ifdef GPIO_HEX_BLANK_EN
  localparam logic [31:0] VIS = 32'((64'd1 << (4 * DIGITS)) - 64'd1);
  assign blank = scan_idx != '0 && ((disp_q & VIS) >> {scan_idx, 2'b00}) == 32'd0;
`else
  assign blank = 1'b0;
`endif
  // Acceptance window is the incoming sample plus the two held ones
  assign all1    = s2 & h0 & h1;
  assign all0    = ~(s2 | h0 | h1);
  assign gpio_in = 32'(deb);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      disp_q   <= '0;
      scan_idx <= '0;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      hex_an   <= ~DIGITS'(1);
      hex_seg  <= 7'h40;
      s1       <= '0;
      s2       <= '0;
      h0       <= '0;
      h1       <= '0;
      deb      <= '0;
    end else begin
      disp_q   <= gpio_out;
      scan_cnt <= scan_wrap ? '0 : scan_cnt + CW'(1);
      if (scan_wrap) scan_idx <= scan_idx == IW'(DIGITS - 1) ? '0 : scan_idx + IW'(1);
      hex_an   <= ~(DIGITS'(1) << scan_idx);
      hex_seg  <= blank ? 7'h7F : glyph(nib);
      s1       <= sw;
      s2       <= s1;
      deb_cnt  <= deb_wrap ? '0 : deb_cnt + DW'(1);
      if (deb_wrap) begin
        h0  <= s2;
        h1  <= h0;
        deb <= all1 | (deb & ~all0);
      end
    end
endmodule

// File: tb/tb_gpio_hex_io.sv
// tb_gpio_hex_io: reference-model bench for gpio_hex_io with directed and random stimulus.
module tb_gpio_hex_io;
  localparam int DIGITS = 4, SCAN_DIV = 4, DEB_TICK = 2, SW_WIDTH = 8;
`ifdef GPIO_HEX_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] gpio_out = '0;
  logic [7:0]  sw = '0;
  logic [31:0] gpio_in;
  logic [6:0]  hex_seg;
  logic [3:0]  hex_an;
  int tests = 0, fails = 0;
  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  gpio_hex_io #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEB_TICK(DEB_TICK), .SW_WIDTH(SW_WIDTH)) dut (
    .clk(clk), .rst(rst), .gpio_out(gpio_out), .sw(sw),
    .gpio_in(gpio_in), .hex_seg(hex_seg), .hex_an(hex_an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_glyph(input logic [31:0] v, input int d);
    logic [15:0] w;
    w = v[15:0];
    if (BLANK && d > 0 && (w >> (4 * d)) == 16'd0) return 7'h7F;
    return gl[(w >> (4 * d)) & 16'hF];
  endfunction

  // Model: edges since reset give the scanned digit and the debounce tick phase;
  // the display shows the word seen two edges back, switches arrive two edges late.
  int          n;
  logic [31:0] dq, exp_gi;
  logic [7:0]  swd [2];
  logic [7:0]  win [3];
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; dq = '0; exp_gi = '0; swd[0] = '0; swd[1] = '0;
      win[0] = '0; win[1] = '0; win[2] = '0;
      exp_an = 4'b1110; exp_seg = 7'h40;
    end else begin
      exp_an  = ~(4'b1 << ((n / SCAN_DIV) % DIGITS));
      exp_seg = exp_glyph(dq, (n / SCAN_DIV) % DIGITS);
      if (n % DEB_TICK == DEB_TICK - 1) begin
        win[2] = win[1]; win[1] = win[0]; win[0] = swd[1];
        for (int k = 0; k < SW_WIDTH; k++)
          if (win[0][k] && win[1][k] && win[2][k]) exp_gi[k] = 1'b1;
          else if (!win[0][k] && !win[1][k] && !win[2][k]) exp_gi[k] = 1'b0;
      end
      swd[1] = swd[0]; swd[0] = sw; dq = gpio_out; n++;
    end
  end

  always @(negedge clk) begin
    chk("cyc_an", 32'(hex_an), 32'(exp_an));
    chk("cyc_seg", 32'(hex_seg), 32'(exp_seg));
    chk("cyc_gpio_in", gpio_in, exp_gi);
  end

  logic [6:0] cap_seg [4];
  int         cap_cnt [4];
  task automatic capture(input logic [31:0] v);
    @(negedge clk); gpio_out = v;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin cap_cnt[d] = 0; cap_seg[d] = 7'h7F; end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (hex_an == ~(4'b1 << d)) begin cap_seg[d] = hex_seg; cap_cnt[d]++; end
    end
  endtask

  task automatic check_caps(input string tag, input logic [6:0] e0, e1, e2, e3);
    logic [6:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_seg%0d", tag, d), 32'(cap_seg[d]), 32'(e[d]));
      chk($sformatf("%s_hold%0d", tag, d), cap_cnt[d], 32'd4);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #3 rst = 1'b1;
    #1;
    chk("rst_an", 32'(hex_an), 32'h0000000E);
    chk("rst_seg", 32'(hex_seg), 32'h40);
    chk("rst_gpio_in", gpio_in, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // digit i shows nibble i: 3, C, 5, A
    capture(32'h0000_A5C3);
    check_caps("scan", 7'h30, 7'h46, 7'h12, 7'h08);
    @(negedge clk); sw = 8'h5A;
    repeat (6) @(negedge clk);
    chk("deb_early", gpio_in, 32'h0);
    repeat (2) @(negedge clk);
    chk("deb_accept", gpio_in, 32'h5A);
    for (int i = 0; i < 20; i++) begin
      sw[0] = ~sw[0];
      repeat (2) @(negedge clk);
      chk("deb_reject", gpio_in, 32'h5A);
    end
    capture(32'h0);
    check_caps("zero", 7'h40, BLANK ? 7'h7F : 7'h40, BLANK ? 7'h7F : 7'h40, BLANK ? 7'h7F : 7'h40);
    capture(32'h1000);
    check_caps("lead1", 7'h40, 7'h40, 7'h40, 7'h79);
    @(negedge clk); sw = 8'hC3;
    for (int t = 0; t < 40 && hex_an !== 4'b1011; t++) @(negedge clk);
    chk("wait_1011", 32'(hex_an), 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("rst2_an", 32'(hex_an), 32'hE);
    chk("rst2_seg", 32'(hex_seg), 32'h40);
    chk("rst2_gpio_in", gpio_in, 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst2_hist", gpio_in, 32'h0);
    end
    repeat (2) @(negedge clk);
    chk("rst2_accept", gpio_in, 32'hC3);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 7) == 0) gpio_out = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin #1 rst = 1'b1; #2 rst = 1'b0; end
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
